// File: rtl/game_pkg.sv
// Shared game-flow types and port-width helpers for the controller, renderer and score blocks.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package game_pkg;

   typedef enum logic [2:0] {
      ATTRACT  = 3'd0,
      PLAY     = 3'd1,
      RESPAWN  = 3'd2,
      LEVEL_UP = 3'd3,
      WIN      = 3'd4,
      GAMEOVER = 3'd5
   } game_state_t;

   // Width of a counter that must hold 0..max_lives inclusive.
   function automatic int lives_w(input int max_lives);
      return $clog2(max_lives + 1);
   endfunction

   // Width of a zero-based wave index; a single-level build still gets one bit.
   function automatic int level_w(input int n_levels);
      return (n_levels > 1) ? $clog2(n_levels) : 1;
   endfunction

endpackage

// File: rtl/game_delay_timer.sv
// Dwell up-counter: runs while clr_i is low, flags done on its PAUSE_CYCLES-th cycle.
// Latency: done_o is high in the PAUSE_CYCLES-th cycle after clr_i drops; the count saturates there.
// Backpressure: none; clr_i resets the count to zero on the next edge.
// Ports: clk, reset (async active-low), clr_i (hold at zero), done_o (count reached PAUSE_CYCLES-1).
module game_delay_timer #(
   parameter int PAUSE_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clr_i,
   output logic done_o
);

   localparam int            TW   = $clog2(PAUSE_CYCLES + 1);
   localparam logic [TW-1:0] LAST = TW'(PAUSE_CYCLES - 1);

   logic [TW-1:0] cnt_q;
   logic [TW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (cnt_q != LAST) begin
         // Saturate at LAST so a stalled consumer never sees the count wrap.
         cnt_d = cnt_q + TW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done_o = !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/game_ctrl_fsm.sv
// Game-flow controller: attract/play/respawn/level-up/win/game-over, lives and level counters.
// Latency: all outputs registered; state/lives/level/pulses update on the edge sampling the condition.
// Backpressure: pause freezes PLAY (inputs ignored); dwell states ignore every input.
// Ports: clk, reset (async active-low), start, pause, player_hit, invaders_alive, invader_row in;
//        state, lives, level, freeze, wave_load, player_respawn out.
module game_ctrl_fsm
   import game_pkg::*;
#(
   parameter int N_INVADERS   = 20,
   parameter int ROW_W        = 4,
   parameter int LOSE_ROW     = 14,
   parameter int MAX_LIVES    = 3,
   parameter int N_LEVELS     = 4,
   parameter int PAUSE_CYCLES = 50_000_000
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             start,
   input  logic                             pause,
   input  logic                             player_hit,
   input  logic [N_INVADERS-1:0]            invaders_alive,
   input  logic [ROW_W-1:0]                 invader_row,
   output game_state_t                      state,
   output logic [lives_w(MAX_LIVES)-1:0]    lives,
   output logic [level_w(N_LEVELS)-1:0]     level,
   output logic                             freeze,
   output logic                             wave_load,
   output logic                             player_respawn
);

   localparam int            LW         = lives_w(MAX_LIVES);
   localparam int            VW         = level_w(N_LEVELS);
   localparam logic [LW-1:0] LIVES_INIT = LW'(MAX_LIVES);
   localparam logic [VW-1:0] LEVEL_LAST = VW'(N_LEVELS - 1);

   game_state_t   state_q, state_d;
   logic [LW-1:0] lives_q, lives_d;
   logic [VW-1:0] level_q, level_d;
   logic          freeze_q, freeze_d;
   logic          wave_load_q, wave_load_d;
   logic          respawn_q, respawn_d;

   logic          in_dwell;
   logic          timer_done;
   logic          row_lost;
   logic          last_level;

   // The timer is held clear outside the dwell states, so it always starts
   // from zero on the first cycle of RESPAWN or LEVEL_UP.
   assign in_dwell   = (state_q == RESPAWN) || (state_q == LEVEL_UP);
   assign row_lost   = 32'(invader_row) >= LOSE_ROW;
   assign last_level = (level_q == LEVEL_LAST);

   game_delay_timer #(
      .PAUSE_CYCLES(PAUSE_CYCLES)
   ) u_dwell (
      .clk   (clk),
      .reset (reset),
      .clr_i (!in_dwell),
      .done_o(timer_done)
   );

   always_comb begin
      state_d     = state_q;
      lives_d     = lives_q;
      level_d     = level_q;
      wave_load_d = 1'b0;
      respawn_d   = 1'b0;

      case (state_q)
         ATTRACT: begin
            if (start) begin
               state_d     = PLAY;
               lives_d     = LIVES_INIT;
               level_d     = '0;
               wave_load_d = 1'b1;
               respawn_d   = 1'b1;
            end
         end
         PLAY: begin
            // Priority: invasion, then hit, then wave clear; a hit that
            // coincides with a clear therefore wins.
            if (!pause) begin
               if (row_lost) begin
                  state_d = GAMEOVER;
               end else if (player_hit) begin
                  if (lives_q <= LW'(1)) begin
                     lives_d = '0;
                     state_d = GAMEOVER;
                  end else begin
                     lives_d = lives_q - LW'(1);
                     state_d = RESPAWN;
                  end
               end else if (invaders_alive == '0) begin
                  state_d = last_level ? WIN : LEVEL_UP;
               end
            end
         end
         RESPAWN: begin
            if (timer_done) begin
               state_d   = PLAY;
               respawn_d = 1'b1;
            end
         end
         LEVEL_UP: begin
            if (timer_done) begin
               state_d     = PLAY;
               wave_load_d = 1'b1;
               respawn_d   = 1'b1;
               if (!last_level) begin
                  level_d = level_q + VW'(1);
               end
            end
         end
         WIN, GAMEOVER: begin
            if (start) begin
               state_d = ATTRACT;
            end
         end
         default: begin
            state_d = ATTRACT;
         end
      endcase

      // Registered alongside state so freeze and state always agree; pause
      // reaches freeze one edge late.
      freeze_d = !((state_d == PLAY) && !pause);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ATTRACT;
         lives_q     <= '0;
         level_q     <= '0;
         freeze_q    <= 1'b1;
         wave_load_q <= 1'b0;
         respawn_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         lives_q     <= lives_d;
         level_q     <= level_d;
         freeze_q    <= freeze_d;
         wave_load_q <= wave_load_d;
         respawn_q   <= respawn_d;
      end
   end

   assign state          = state_q;
   assign lives          = lives_q;
   assign level          = level_q;
   assign freeze         = freeze_q;
   assign wave_load      = wave_load_q;
   assign player_respawn = respawn_q;

endmodule
